// File: rtl/zbb_bitcount_seq.sv
`default_nettype none
// zbb_bitcount_seq: iterative Zbb clz/ctz/cpop unit, scans BITS_PER_CYCLE bits per clock. Rev 1.0
// Optional build macro ZBB_BITCOUNT_EARLY_EXIT_EN: leave RUN as soon as the count is final.
module zbb_bitcount_seq #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] din_rs1,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout_rd
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      sh_q, sh_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [31:0]      dout_q, dout_d;

  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [5:0]                cnt_step;
  logic [5:0]                cnt_run;
  logic                      found_run;
  logic [31:0]               sh_run;
  logic                      run_end;
  logic                      accept;
  logic [31:0]               rs1_rev;

  function automatic logic [5:0] lead_zeros(input logic [BITS_PER_CYCLE-1:0] c);
    logic [5:0] n;
    logic       seen;
    n    = 6'd0;
    seen = 1'b0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      if (c[i]) seen = 1'b1;
      else if (!seen) n = n + 6'd1;
    end
    return n;
  endfunction

  function automatic logic [5:0] pop_count(input logic [BITS_PER_CYCLE-1:0] c);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      n = n + {5'd0, c[i]};
    end
    return n;
  endfunction

  // ctz is a clz of the reversed operand, so both share the MSB-first scan
  always_comb begin
    rs1_rev = '0;
    for (int i = 0; i < 32; i++) begin
      rs1_rev[i] = din_rs1[31-i];
    end
  end

  always_comb begin
    chunk     = sh_q[31 -: BITS_PER_CYCLE];
    cnt_step  = (op_q == OP_CPOP) ? pop_count(chunk)
                                  : (found_q ? 6'd0 : lead_zeros(chunk));
    cnt_run   = cnt_q + cnt_step;
    found_run = found_q | (|chunk);
    sh_run    = sh_q << BITS_PER_CYCLE;
    run_end   = (chunk_q == LAST_CHUNK);
`ifdef ZBB_BITCOUNT_EARLY_EXIT_EN
    if (op_q == OP_CPOP) run_end = run_end | (sh_run == 32'd0);
    else                 run_end = run_end | found_run;
`endif
  end

  assign accept = start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    chunk_d = chunk_q;
    dout_d  = dout_q;

    case (state_q)
      S_RUN: begin
        cnt_d   = cnt_run;
        found_d = found_run;
        sh_d    = sh_run;
        chunk_d = chunk_q + CW'(1);
        if (run_end) begin
          state_d = S_DONE;
          dout_d  = {26'd0, cnt_run};
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (accept) begin
          op_d    = op;
          sh_d    = (op == OP_CTZ) ? rs1_rev : din_rs1;
          cnt_d   = 6'd0;
          found_d = 1'b0;
          chunk_d = '0;
          if (op == OP_RSVD) begin
            state_d = S_DONE;
            dout_d  = 32'd0;
          end else begin
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_CLZ;
      sh_q    <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      chunk_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      chunk_q <= chunk_d;
      dout_q  <= dout_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign dout_rd = dout_q;

endmodule
`default_nettype wire
